regfile_rename: RTL and testbench

//  Parametrised architectural register file with per-register rename status for the Tomasulo core.

---
 rtl/regfile_rename_pkg.sv | 34 +++
 rtl/regfile_rename_rd_port.sv | 62 ++++++
 rtl/regfile_rename.sv | 125 ++++++++++++
 tb/tb_regfile_rename.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_rename_pkg.sv
// Shared types and default sizes for the renaming register file.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle commit-to-read forwarding).
`ifndef GPR_SIZE
`define GPR_SIZE 64
`endif
`ifndef GPR_IDX_SIZE
`define GPR_IDX_SIZE 5
`endif

package regfile_rename_pkg;

  localparam int RF_NUM_REGS = 32;
  localparam int RF_IDX_W    = `GPR_IDX_SIZE;
  localparam int RF_DATA_W   = `GPR_SIZE;
  localparam int RF_TAG_W    = 4;
  localparam int RF_NUM_RD   = 4;
  localparam int RF_NUM_CMT  = 2;
  localparam int RF_ZERO_REG = 31;

  // One architectural register: committed value plus rename status.
  typedef struct packed {
    logic [RF_DATA_W-1:0] value;
    logic                 busy;
    logic [RF_TAG_W-1:0]  tag;
  } rf_entry_t;

  // What a dispatch read returns: a value when ready, else the producer tag.
  typedef struct packed {
    logic [RF_DATA_W-1:0] value;
    logic                 ready;
    logic [RF_TAG_W-1:0]  tag;
  } rf_rd_resp_t;

endpackage

// File: rtl/regfile_rename_rd_port.sv
// One dispatch read port: selects a register and reports value-or-tag.
// Optional feature macro: REGFILE_BYPASS_EN forwards a same-cycle commit whose
// tag matches the pending producer of the selected register.
module regfile_rename_rd_port
  import regfile_rename_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int DATA_W   = RF_DATA_W,
  parameter int TAG_W    = RF_TAG_W,
  parameter int NUM_CMT  = RF_NUM_CMT,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic [IDX_W-1:0]          rd_idx,
  input  logic [NUM_REGS*DATA_W-1:0] rf_value,
  input  logic [NUM_REGS-1:0]        rf_busy,
  input  logic [NUM_REGS*TAG_W-1:0]  rf_tag,
  input  logic [NUM_CMT-1:0]         cmt_valid,
  input  logic [NUM_CMT*IDX_W-1:0]   cmt_idx,
  input  logic [NUM_CMT*TAG_W-1:0]   cmt_tag,
  input  logic [NUM_CMT*DATA_W-1:0]  cmt_value,
  output logic [DATA_W-1:0]          rd_value,
  output logic                       rd_ready,
  output logic [TAG_W-1:0]           rd_tag
);

`ifndef REGFILE_BYPASS_EN
  // Commit inputs only matter when forwarding is built in.
  logic unused_cmt;
  assign unused_cmt = ^{cmt_valid, cmt_idx, cmt_tag, cmt_value};
`endif

  // Read mux; an index with no backing register reports not-ready with zeros.
  // The zero register needs no special case: its storage is never written.
  always_comb begin
    rd_value = '0;
    rd_ready = 1'b0;
    rd_tag   = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rd_idx == IDX_W'(r)) begin
        if (rf_busy[r]) begin
          rd_tag = rf_tag[r*TAG_W +: TAG_W];
`ifdef REGFILE_BYPASS_EN
          // Ascending scan so the highest matching commit port wins.
          for (int c = 0; c < NUM_CMT; c++) begin
            if (cmt_valid[c] &&
                cmt_idx[c*IDX_W +: IDX_W] == IDX_W'(r) &&
                cmt_tag[c*TAG_W +: TAG_W] == rf_tag[r*TAG_W +: TAG_W]) begin
              rd_ready = 1'b1;
              rd_value = cmt_value[c*DATA_W +: DATA_W];
              rd_tag   = '0;
            end
          end
`endif
        end else begin
          rd_ready = 1'b1;
          rd_value = rf_value[r*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename status (busy + ROB tag).
// Dispatch reads are combinational; rename, commit and flush update on the edge.
// Optional feature macro: REGFILE_BYPASS_EN (see regfile_rename_rd_port).
module regfile_rename
  import regfile_rename_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int DATA_W   = RF_DATA_W,
  parameter int TAG_W    = RF_TAG_W,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int NUM_CMT  = RF_NUM_CMT,
  parameter int ZERO_REG = RF_ZERO_REG,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic                      in_clk,
  input  logic                      in_rst_n,
  input  logic [NUM_RD*IDX_W-1:0]   in_rd_idx,
  output logic [NUM_RD*DATA_W-1:0]  out_rd_value,
  output logic [NUM_RD-1:0]         out_rd_ready,
  output logic [NUM_RD*TAG_W-1:0]   out_rd_tag,
  input  logic                      in_ren_valid,
  input  logic [IDX_W-1:0]          in_ren_idx,
  input  logic [TAG_W-1:0]          in_ren_tag,
  input  logic [NUM_CMT-1:0]        in_cmt_valid,
  input  logic [NUM_CMT*IDX_W-1:0]  in_cmt_idx,
  input  logic [NUM_CMT*TAG_W-1:0]  in_cmt_tag,
  input  logic [NUM_CMT*DATA_W-1:0] in_cmt_value,
  input  logic                      in_flush,
  output logic [IDX_W:0]            out_busy_count
);

  logic [DATA_W-1:0]  value_q [NUM_REGS];
  logic [DATA_W-1:0]  value_d [NUM_REGS];
  logic [TAG_W-1:0]   tag_q   [NUM_REGS];
  logic [TAG_W-1:0]   tag_d   [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [IDX_W:0]     count_q, count_d;

  logic [NUM_REGS*DATA_W-1:0] rf_value_flat;
  logic [NUM_REGS*TAG_W-1:0]  rf_tag_flat;

  // Next-state: commits in port order (younger overrides), then rename, then flush.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      value_d[r] = value_q[r];
      tag_d[r]   = tag_q[r];
    end
    busy_d  = busy_q;
    count_d = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (r != ZERO_REG) begin
        for (int c = 0; c < NUM_CMT; c++) begin
          if (in_cmt_valid[c] && in_cmt_idx[c*IDX_W +: IDX_W] == IDX_W'(r)) begin
            value_d[r] = in_cmt_value[c*DATA_W +: DATA_W];
            // A stale tag leaves busy alone; the youngest port to this register decides.
            busy_d[r]  = busy_q[r] && (tag_q[r] != in_cmt_tag[c*TAG_W +: TAG_W]);
          end
        end
        if (in_ren_valid && !in_flush && in_ren_idx == IDX_W'(r)) begin
          busy_d[r] = 1'b1;
          tag_d[r]  = in_ren_tag;
        end
      end
    end
    if (in_flush) begin
      busy_d = '0;
    end
    for (int r = 0; r < NUM_REGS; r++) begin
      count_d = count_d + (IDX_W+1)'(busy_d[r]);
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        value_q[r] <= '0;
        tag_q[r]   <= '0;
      end
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        value_q[r] <= value_d[r];
        tag_q[r]   <= tag_d[r];
      end
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  // Flatten the entry array for the read ports.
  always_comb begin
    rf_value_flat = '0;
    rf_tag_flat   = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      rf_value_flat[r*DATA_W +: DATA_W] = value_q[r];
      rf_tag_flat[r*TAG_W +: TAG_W]     = tag_q[r];
    end
  end

  assign out_busy_count = count_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rename_rd_port #(
      .NUM_REGS (NUM_REGS),
      .DATA_W   (DATA_W),
      .TAG_W    (TAG_W),
      .NUM_CMT  (NUM_CMT)
    ) u_rd_port (
      .rd_idx    (in_rd_idx[p*IDX_W +: IDX_W]),
      .rf_value  (rf_value_flat),
      .rf_busy   (busy_q),
      .rf_tag    (rf_tag_flat),
      .cmt_valid (in_cmt_valid),
      .cmt_idx   (in_cmt_idx),
      .cmt_tag   (in_cmt_tag),
      .cmt_value (in_cmt_value),
      .rd_value  (out_rd_value[p*DATA_W +: DATA_W]),
      .rd_ready  (out_rd_ready[p]),
      .rd_tag    (out_rd_tag[p*TAG_W +: TAG_W])
    );
  end

endmodule

// File: tb/tb_regfile_rename.sv
// Directed bench for regfile_rename at default parameters.
// Expected values track the REGFILE_BYPASS_EN build macro where behaviour differs.
module tb_regfile_rename;

  localparam int IDX_W = 5;
  localparam int DATA_W = 64;
  localparam int TAG_W = 4;
  localparam int NUM_RD = 4;
  localparam int NUM_CMT = 2;

  logic                      in_clk;
  logic                      in_rst_n;
  logic [NUM_RD*IDX_W-1:0]   in_rd_idx;
  logic [NUM_RD*DATA_W-1:0]  out_rd_value;
  logic [NUM_RD-1:0]         out_rd_ready;
  logic [NUM_RD*TAG_W-1:0]   out_rd_tag;
  logic                      in_ren_valid;
  logic [IDX_W-1:0]          in_ren_idx;
  logic [TAG_W-1:0]          in_ren_tag;
  logic [NUM_CMT-1:0]        in_cmt_valid;
  logic [NUM_CMT*IDX_W-1:0]  in_cmt_idx;
  logic [NUM_CMT*TAG_W-1:0]  in_cmt_tag;
  logic [NUM_CMT*DATA_W-1:0] in_cmt_value;
  logic                      in_flush;
  logic [IDX_W:0]            out_busy_count;

  int n_checks = 0;
  int n_fail = 0;

  regfile_rename dut (
    .in_clk         (in_clk),
    .in_rst_n       (in_rst_n),
    .in_rd_idx      (in_rd_idx),
    .out_rd_value   (out_rd_value),
    .out_rd_ready   (out_rd_ready),
    .out_rd_tag     (out_rd_tag),
    .in_ren_valid   (in_ren_valid),
    .in_ren_idx     (in_ren_idx),
    .in_ren_tag     (in_ren_tag),
    .in_cmt_valid   (in_cmt_valid),
    .in_cmt_idx     (in_cmt_idx),
    .in_cmt_tag     (in_cmt_tag),
    .in_cmt_value   (in_cmt_value),
    .in_flush       (in_flush),
    .out_busy_count (out_busy_count)
  );

  // Clock: 10 ns period, rising edges at 5, 15, ...
  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  // Single comparison point: counts every check, reports mismatches.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic idle();
    in_ren_valid = 1'b0;
    in_ren_idx   = '0;
    in_ren_tag   = '0;
    in_cmt_valid = '0;
    in_cmt_idx   = '0;
    in_cmt_tag   = '0;
    in_cmt_value = '0;
    in_flush     = 1'b0;
  endtask

  task automatic rd(input int p, input int idx);
    in_rd_idx[p*IDX_W +: IDX_W] = IDX_W'(idx);
  endtask

  task automatic rename(input int idx, input int tag);
    in_ren_valid = 1'b1;
    in_ren_idx   = IDX_W'(idx);
    in_ren_tag   = TAG_W'(tag);
  endtask

  task automatic commit(input int c, input int idx, input int tag, input logic [63:0] val);
    in_cmt_valid[c]                  = 1'b1;
    in_cmt_idx[c*IDX_W +: IDX_W]     = IDX_W'(idx);
    in_cmt_tag[c*TAG_W +: TAG_W]     = TAG_W'(tag);
    in_cmt_value[c*DATA_W +: DATA_W] = val;
  endtask

  // Advance one edge; inputs and samples happen 1 ns after the rising edge.
  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  // Check one read port against value / ready / tag.
  task automatic expect_rd(input string tag, input int p,
                           input logic [63:0] val, input logic rdy, input int t);
    check({tag, ".value"}, out_rd_value[p*DATA_W +: DATA_W], val);
    check({tag, ".ready"}, 64'(out_rd_ready[p]), 64'(rdy));
    check({tag, ".tag"}, 64'(out_rd_tag[p*TAG_W +: TAG_W]), 64'(t));
  endtask

  initial begin
    in_rst_n  = 1'b0;
    in_rd_idx = '0;
    idle();

    // 1. Reset state
    for (int p = 0; p < NUM_RD; p++) rd(p, p);
    #2;
    for (int p = 0; p < NUM_RD; p++) expect_rd($sformatf("reset_r%0d", p), p, 64'h0, 1'b1, 0);
    check("reset_busy_count", 64'(out_busy_count), 64'd0);
    #1 in_rst_n = 1'b1;
    tick();

    // 2. Rename r5 tag 3, then commit it
    rename(5, 3);
    tick();
    idle();
    rd(0, 5);
    #1;
    expect_rd("r5_busy", 0, 64'h0, 1'b0, 3);
    check("count_after_r5", 64'(out_busy_count), 64'd1);
    commit(0, 5, 3, 64'hAB);
    tick();
    idle();
    #1;
    expect_rd("r5_committed", 0, 64'hAB, 1'b1, 0);
    check("count_after_r5_cmt", 64'(out_busy_count), 64'd0);

    // 3. Double rename of r7, stale commit of the older tag
    rename(7, 2);
    tick();
    rename(7, 6);
    tick();
    idle();
    commit(0, 7, 2, 64'd9);
    tick();
    idle();
    rd(1, 7);
    #1;
    expect_rd("r7_stale", 1, 64'h0, 1'b0, 6);
    in_flush = 1'b1;
    tick();
    idle();
    #1;
    expect_rd("r7_value_kept", 1, 64'd9, 1'b1, 0);

    // 4. Two commit ports to r4: younger port wins
    commit(0, 4, 0, 64'd1);
    commit(1, 4, 0, 64'd2);
    tick();
    idle();
    rd(2, 4);
    #1;
    expect_rd("r4_dual_cmt", 2, 64'd2, 1'b1, 0);
    // Rename and commit to r4 in the same cycle
    rename(4, 5);
    commit(0, 4, 0, 64'd7);
    tick();
    idle();
    #1;
    expect_rd("r4_ren_cmt", 2, 64'h0, 1'b0, 5);
    in_flush = 1'b1;
    tick();
    idle();
    #1;
    expect_rd("r4_cmt_value", 2, 64'd7, 1'b1, 0);
    // Stale on port 0, matching on port 1: busy clears, port 1 value wins
    rename(6, 1);
    tick();
    idle();
    commit(0, 6, 9, 64'd3);
    commit(1, 6, 1, 64'd4);
    tick();
    idle();
    rd(3, 6);
    #1;
    expect_rd("r6_port1_match", 3, 64'd4, 1'b1, 0);

    // 5. Same-cycle commit and read of r8
    rename(8, 1);
    tick();
    idle();
    commit(1, 8, 1, 64'h55);
    rd(2, 8);
    #1;
`ifdef REGFILE_BYPASS_EN
    expect_rd("r8_same_cycle", 2, 64'h55, 1'b1, 0);
`else
    expect_rd("r8_same_cycle", 2, 64'h0, 1'b0, 1);
`endif
    tick();
    idle();
    #1;
    expect_rd("r8_next_cycle", 2, 64'h55, 1'b1, 0);

    // 6. Three renames then flush (a same-cycle rename is dropped)
    rename(1, 1);
    tick();
    rename(2, 2);
    tick();
    rename(3, 3);
    tick();
    idle();
    check("count_three_busy", 64'(out_busy_count), 64'd3);
    in_flush = 1'b1;
    rename(9, 4);
    tick();
    idle();
    check("count_after_flush", 64'(out_busy_count), 64'd0);
    rd(0, 1); rd(1, 2); rd(2, 3); rd(3, 9);
    #1;
    expect_rd("flush_r1", 0, 64'h0, 1'b1, 0);
    expect_rd("flush_r2", 1, 64'h0, 1'b1, 0);
    expect_rd("flush_r3", 2, 64'h0, 1'b1, 0);
    expect_rd("flush_r9_dropped", 3, 64'h0, 1'b1, 0);

    // Zero register ignores rename and commit
    rename(31, 7);
    commit(0, 31, 0, 64'hFF);
    tick();
    idle();
    rd(0, 31);
    #1;
    expect_rd("r31_zero", 0, 64'h0, 1'b1, 0);
    check("count_r31", 64'(out_busy_count), 64'd0);

    // Asynchronous reset mid-cycle
    rename(10, 2);
    tick();
    idle();
    commit(0, 11, 0, 64'h77);
    tick();
    idle();
    rd(0, 10); rd(1, 11);
    #1;
    expect_rd("pre_reset_r10", 0, 64'h0, 1'b0, 2);
    expect_rd("pre_reset_r11", 1, 64'h77, 1'b1, 0);
    rename(12, 5);
    #1 in_rst_n = 1'b0;
    #1;
    expect_rd("async_reset_r10", 0, 64'h0, 1'b1, 0);
    expect_rd("async_reset_r11", 1, 64'h0, 1'b1, 0);
    check("async_reset_count", 64'(out_busy_count), 64'd0);
    idle();
    #1 in_rst_n = 1'b1;
    tick();
    rd(2, 12);
    #1;
    expect_rd("post_reset_r12", 2, 64'h0, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
